display_bitplane_scanner: RTL

// Reads colour-encoded pixel words (output format of display_color_encoder) from the line/frame

---
 rtl/display_bitplane_scanner_if.sv | 29 ++
 rtl/display_bitplane_scanner.sv | 130 +++++++++++++
 2 files changed

// File: rtl/display_bitplane_scanner_if.sv
// Pin-side bundle of the BCM panel scanner: pixel buffer read port plus HUB75 panel outputs.
// The scanner is the master; the buffer/panel side is the slave.
interface display_bitplane_scanner_if #(
  parameter int segments = 2,
  parameter int bitwidth = 8,
  parameter int columns  = 64,
  parameter int rowbits  = 5
);
  localparam int colbits = $clog2(columns);

  logic                             enable;
  logic [rowbits+colbits-1:0]       pixel_addr;
  logic [segments*3*bitwidth-1:0]   cpixel;
  logic [segments*3-1:0]            display_rgb;
  logic                             display_clk;
  logic                             display_latch;
  logic                             display_oe_n;
  logic [rowbits-1:0]               display_row;

  modport master (
    input  enable, cpixel,
    output pixel_addr, display_rgb, display_clk, display_latch, display_oe_n, display_row
  );

  modport slave (
    output enable, cpixel,
    input  pixel_addr, display_rgb, display_clk, display_latch, display_oe_n, display_row
  );
endinterface

// File: rtl/display_bitplane_scanner.sv
// HUB75 panel driver using binary code modulation: per row and bit plane it shifts one column
// bit per channel, latches, then lights the panel for a time weighted by the plane significance.
module display_bitplane_scanner #(
  parameter int segments    = 2,
  parameter int bitwidth    = 8,
  parameter int columns     = 64,
  parameter int rowbits     = 5,
  parameter int base_cycles = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  display_bitplane_scanner_if.master   bus
);
  localparam int colbits = $clog2(columns);
  localparam int cw      = $clog2(base_cycles) + bitwidth;
  localparam int sw      = $clog2(2*columns + 2);
  localparam int pw      = (bitwidth > 1) ? $clog2(bitwidth) : 1;

  localparam logic [sw-1:0] last_step  = sw'(2*columns + 1);
  localparam logic [sw-1:0] last_fetch = sw'(2*columns - 1);
  localparam logic [pw-1:0] last_plane = pw'(bitwidth - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;

  state_t               state;
  logic [sw-1:0]        step;
  logic [cw-1:0]        dcnt;
  logic [pw-1:0]        plane;
  logic [rowbits-1:0]   row;

  logic [cw-1:0]        disp_len;
  logic [rowbits-1:0]   row_adv;
  logic [colbits-1:0]   next_col;

  // Picks the current plane bit of R, G and B for every segment (R is the top field).
  function automatic logic [segments*3-1:0] plane_bits(
    input logic [segments*3*bitwidth-1:0] px,
    input logic [pw-1:0]                  p
  );
    logic [segments*3-1:0] b;
    logic [3*bitwidth-1:0] seg;
    logic [bitwidth-1:0]   r, g, bl;
    b = '0;
    for (int s = 0; s < segments; s++) begin
      seg = px[s*3*bitwidth +: 3*bitwidth];
      r   = seg[2*bitwidth +: bitwidth];
      g   = seg[bitwidth +: bitwidth];
      bl  = seg[0 +: bitwidth];
      b[3*s+2] = r[p];
      b[3*s+1] = g[p];
      b[3*s]   = bl[p];
    end
    return b;
  endfunction

  assign disp_len = cw'(base_cycles) << plane;
  assign row_adv  = (plane == last_plane) ? row + rowbits'(1) : row;
  assign next_col = step[colbits:1] + colbits'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      step              <= '0;
      dcnt              <= '0;
      plane             <= '0;
      row               <= '0;
      bus.pixel_addr    <= '0;
      bus.display_rgb   <= '0;
      bus.display_clk   <= 1'b0;
      bus.display_latch <= 1'b0;
      bus.display_oe_n  <= 1'b1;
      bus.display_row   <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.display_oe_n  <= 1'b1;
          bus.display_clk   <= 1'b0;
          bus.display_latch <= 1'b0;
          if (bus.enable) begin
            state          <= SHIFT;
            step           <= '0;
            bus.pixel_addr <= {row, colbits'(0)};
          end
        end
        SHIFT: begin
          step <= step + sw'(1);
          // Even step >= 2 raises the panel clock for the following odd step, when the
          // column captured one step earlier is stable on display_rgb.
          bus.display_clk <= (!step[0]) && (step >= sw'(2));
          if (step[0]) begin
            bus.display_rgb <= plane_bits(bus.cpixel, plane);
            if (step < last_fetch)
              bus.pixel_addr <= {row, next_col};
          end
          if (step == last_step) begin
            state           <= BLANK;
            bus.display_clk <= 1'b0;
          end
        end
        BLANK: begin
          bus.display_row   <= row;
          bus.display_latch <= 1'b1;
          state             <= LATCH;
        end
        LATCH: begin
          bus.display_latch <= 1'b0;
          bus.display_oe_n  <= 1'b0;
          dcnt              <= '0;
          state             <= DISPLAY;
        end
        DISPLAY: begin
          dcnt <= dcnt + cw'(1);
          if (dcnt == disp_len - cw'(1)) begin
            bus.display_oe_n <= 1'b1;
            plane            <= (plane == last_plane) ? '0 : plane + pw'(1);
            row              <= row_adv;
            if (bus.enable) begin
              state          <= SHIFT;
              step           <= '0;
              bus.pixel_addr <= {row_adv, colbits'(0)};
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
